membus_lsu_initiator: RTL and testbench

//  Initiator (master) end of the Membus protocol, used by the core's load/store stage.

---
 rtl/membus_lsu_initiator_pkg.sv | 34 +++
 rtl/membus_lsu_initiator_if.sv | 35 +++
 rtl/membus_lsu_initiator_lane_align.sv | 69 ++++++
 rtl/membus_lsu_initiator.sv | 146 ++++++++++++++
 tb/tb_membus_lsu_initiator.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/membus_lsu_initiator_pkg.sv
// -----------------------------------------------------------------------------
// membus_lsu_initiator_pkg
//   Shared execution-environment definitions for the Membus load/store path:
//   architectural widths, the access-size enum and the alignment rule.
//   No ports (package).
// -----------------------------------------------------------------------------
package membus_lsu_initiator_pkg;

    localparam int XLEN              = 64;
    localparam int MEMBUS_DATA_WIDTH = 64;
    localparam int MEMBUS_MASK_WIDTH = MEMBUS_DATA_WIDTH / 8;

    typedef logic [XLEN-1:0] Addr;
    typedef logic [63:0]     UInt64;

    typedef enum logic [1:0] {
        B = 2'd0,
        H = 2'd1,
        W = 2'd2,
        D = 2'd3
    } MemSize;

    // An access is aligned when its byte offset inside the doubleword is a
    // multiple of its own size.
    function automatic logic is_aligned(MemSize size, logic [2:0] ofs);
        case (size)
            B:       return 1'b1;
            H:       return ofs[0] == 1'b0;
            W:       return ofs[1:0] == 2'b00;
            default: return ofs == 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/membus_lsu_initiator_if.sv
// -----------------------------------------------------------------------------
// membus_lsu_initiator_if
//   Membus request/response bundle.
//   valid/ready : request handshake (master -> slave / slave -> master)
//   addr        : full byte address
//   wen         : 1 = write
//   wdata/wmask : doubleword-aligned write lane and byte enables
//   rvalid      : response strobe (loads and stores)
//   rdata       : doubleword-aligned read lane
// -----------------------------------------------------------------------------
interface membus_lsu_initiator_if
    import membus_lsu_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = XLEN,
    parameter int DATA_WIDTH = MEMBUS_DATA_WIDTH
);
    logic                    valid;
    logic                    ready;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    wen;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wmask;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output valid, addr, wen, wdata, wmask,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, addr, wen, wdata, wmask,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/membus_lsu_initiator_lane_align.sv
// -----------------------------------------------------------------------------
// membus_lsu_initiator_lane_align  (combinational)
//   Request side : alignment check, store data shift and byte-mask generation.
//   Load side    : shift the returned lane down and sign/zero extend.
//   rq_size_i/rq_ofs_i/rq_wdata_i  -> rq_misaligned_o, rq_wdata_o, rq_wmask_o
//   ld_size_i/ld_ofs_i/ld_unsigned_i/ld_rdata_i -> ld_data_o
// -----------------------------------------------------------------------------
module membus_lsu_initiator_lane_align
    import membus_lsu_initiator_pkg::*;
#(
    parameter int DATA_WIDTH = MEMBUS_DATA_WIDTH
) (
    input  MemSize                  rq_size_i,
    input  logic [2:0]              rq_ofs_i,
    input  logic [DATA_WIDTH-1:0]   rq_wdata_i,
    output logic                    rq_misaligned_o,
    output logic [DATA_WIDTH-1:0]   rq_wdata_o,
    output logic [DATA_WIDTH/8-1:0] rq_wmask_o,

    input  MemSize                  ld_size_i,
    input  logic [2:0]              ld_ofs_i,
    input  logic                    ld_unsigned_i,
    input  logic [DATA_WIDTH-1:0]   ld_rdata_i,
    output logic [DATA_WIDTH-1:0]   ld_data_o
);
    localparam int MASK_W = DATA_WIDTH / 8;

    logic [MASK_W-1:0]     mask_base;
    logic [DATA_WIDTH-1:0] ld_shifted;
    logic                  sgn;

    // NOTE: every signal written in an always_comb gets a value on every path
    // (default first), otherwise synthesis infers a latch.
    always_comb begin
        mask_base = MASK_W'(8'hFF);
        case (rq_size_i)
            B:       mask_base = MASK_W'(8'h01);
            H:       mask_base = MASK_W'(8'h03);
            W:       mask_base = MASK_W'(8'h0F);
            default: mask_base = MASK_W'(8'hFF);
        endcase
    end

    assign rq_misaligned_o = !is_aligned(rq_size_i, rq_ofs_i);
    assign rq_wdata_o      = rq_wdata_i << {rq_ofs_i, 3'b000};
    assign rq_wmask_o      = mask_base << rq_ofs_i;

    assign ld_shifted = ld_rdata_i >> {ld_ofs_i, 3'b000};

    always_comb begin
        sgn       = 1'b0;
        ld_data_o = ld_shifted;
        case (ld_size_i)
            B: begin
                sgn       = !ld_unsigned_i && ld_shifted[7];
                ld_data_o = {{(DATA_WIDTH-8){sgn}}, ld_shifted[7:0]};
            end
            H: begin
                sgn       = !ld_unsigned_i && ld_shifted[15];
                ld_data_o = {{(DATA_WIDTH-16){sgn}}, ld_shifted[15:0]};
            end
            W: begin
                sgn       = !ld_unsigned_i && ld_shifted[31];
                ld_data_o = {{(DATA_WIDTH-32){sgn}}, ld_shifted[31:0]};
            end
            default: ld_data_o = ld_shifted;
        endcase
    end
endmodule

// File: rtl/membus_lsu_initiator.sv
// -----------------------------------------------------------------------------
// membus_lsu_initiator
//   Membus master for the load/store stage. One request at a time; misaligned
//   requests are rejected with a misalign pulse and never reach the bus.
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : request handshake (ready only when idle)
//   req_wen/size/unsigned/addr/wdata : request attributes
//   resp_valid/resp_rdata         : completion pulse and extended load data
//   misalign                      : rejection pulse
//   membus                        : Membus master port
// -----------------------------------------------------------------------------
module membus_lsu_initiator
    import membus_lsu_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = XLEN,
    parameter int DATA_WIDTH = MEMBUS_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  MemSize                req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  misalign,
    membus_lsu_initiator_if.master membus
);
    typedef enum logic [1:0] {IDLE, WAIT_READY, WAIT_RVALID} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wen_q, wen_d;
    MemSize                  size_q, size_d;
    logic                    unsigned_q, unsigned_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wmask_q, wmask_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    misalign_q, misalign_d;

    logic                    rq_misaligned;
    logic [DATA_WIDTH-1:0]   rq_wdata;
    logic [DATA_WIDTH/8-1:0] rq_wmask;
    logic [DATA_WIDTH-1:0]   ld_data;

    // Request side works on the incoming request so the shifted lane can be
    // latched directly; load side works on the latched request.
    membus_lsu_initiator_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane_align (
        .rq_size_i       (req_size),
        .rq_ofs_i        (req_addr[2:0]),
        .rq_wdata_i      (req_wdata),
        .rq_misaligned_o (rq_misaligned),
        .rq_wdata_o      (rq_wdata),
        .rq_wmask_o      (rq_wmask),
        .ld_size_i       (size_q),
        .ld_ofs_i        (addr_q[2:0]),
        .ld_unsigned_i   (unsigned_q),
        .ld_rdata_i      (membus.rdata),
        .ld_data_o       (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        misalign_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (rq_misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        addr_d     = req_addr;
                        wen_d      = req_wen;
                        size_d     = req_size;
                        unsigned_d = req_unsigned;
                        wdata_d    = rq_wdata;
                        wmask_d    = rq_wmask;
                        state_d    = WAIT_READY;
                    end
                end
            end
            WAIT_READY: begin
                if (membus.ready) state_d = WAIT_RVALID;
            end
            WAIT_RVALID: begin
                if (membus.rvalid) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = wen_q ? '0 : ld_data;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            size_q       <= B;
            unsigned_q   <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            misalign_q   <= misalign_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign misalign     = misalign_q;

    assign membus.valid = (state_q == WAIT_READY);
    assign membus.addr  = addr_q;
    assign membus.wen   = wen_q;
    assign membus.wdata = wdata_q;
    assign membus.wmask = wmask_q;
endmodule

// File: tb/tb_membus_lsu_initiator.sv
// -----------------------------------------------------------------------------
// tb_membus_lsu_initiator
//   Directed bench. Stimulus and responder behaviour are laid out per cycle in
//   a table; a transaction-level model fills a per-cycle table of expected
//   outputs from the access rules and latency formula, and one compare
//   process checks the DUT against it on every falling edge.
// -----------------------------------------------------------------------------
module tb_membus_lsu_initiator;
    import membus_lsu_initiator_pkg::*;

    localparam int NCYC = 128;
    localparam logic [63:0] GARBAGE = 64'hA5A5_5A5A_DEAD_BEEF;

    typedef struct {
        logic        rq_valid;
        logic        rq_wen;
        logic        rq_uns;
        logic [1:0]  rq_size;
        logic [63:0] rq_addr;
        logic [63:0] rq_wdata;
        logic        ready;
        logic        rvalid;
        logic [63:0] rdata;
        logic        rst;
    } stim_t;

    typedef struct {
        logic        ready;
        logic        bus_valid;
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic        resp_valid;
        logic        rdata_known;
        logic [63:0] rdata;
        logic        misalign;
    } exp_t;

    stim_t stim  [NCYC];
    exp_t  exp_c [NCYC];

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    MemSize      req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, misalign;
    logic [63:0] resp_rdata;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    membus_lsu_initiator_if bus ();

    membus_lsu_initiator dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .misalign     (misalign),
        .membus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model ----------------
    function automatic logic [63:0] model_load(logic [63:0] rdata, logic [63:0] addr,
                                               logic [1:0] size, logic uns);
        int          bits;
        logic [63:0] v;
        logic [63:0] lim;
        bits = 8 * (1 << size);
        v    = rdata >> (8 * (addr % 8));
        if (bits < 64) begin
            lim = (64'd1 << bits) - 64'd1;
            v   = v & lim;
            if (!uns && v[bits-1]) v = v | ~lim;
        end
        return v;
    endfunction

    // Plans one request presented in cycle t. abort=1 pulses rst in the first
    // cycle after the bus transfer and sends a late rvalid the cycle after.
    task automatic plan_req(input int t, input logic wen, input logic [1:0] size,
                            input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [63:0] rdata, input int nwait, input int dly,
                            input logic abort, output int t_next);
        int nb;
        int ofs;
        nb  = 1 << size;
        ofs = int'(addr % 8);
        stim[t].rq_valid = 1'b1;
        stim[t].rq_wen   = wen;
        stim[t].rq_uns   = uns;
        stim[t].rq_size  = size;
        stim[t].rq_addr  = addr;
        stim[t].rq_wdata = wdata;
        if ((addr % 64'(nb)) != 0) begin
            exp_c[t+1].misalign = 1'b1;
            t_next = t + 1;
            return;
        end
        for (int k = 1; k <= 1 + nwait; k++) begin
            exp_c[t+k].bus_valid = 1'b1;
            exp_c[t+k].addr      = addr;
            exp_c[t+k].wen       = wen;
            exp_c[t+k].wdata     = wdata << (8 * ofs);
            exp_c[t+k].wmask     = 8'(((1 << nb) - 1) << ofs);
        end
        for (int k = 1; k <= nwait; k++) stim[t+k].ready = 1'b0;
        if (abort) begin
            for (int k = 1; k <= 2 + nwait; k++) exp_c[t+k].ready = 1'b0;
            stim[t+2+nwait].rst    = 1'b1;
            stim[t+3+nwait].rvalid = 1'b1;
            stim[t+3+nwait].rdata  = rdata;
            exp_c[t+3+nwait].rdata_known = 1'b1;
            exp_c[t+3+nwait].rdata       = '0;
            t_next = t + 4 + nwait;
        end else begin
            for (int k = 1; k <= 1 + nwait + dly; k++) exp_c[t+k].ready = 1'b0;
            stim[t+1+nwait+dly].rvalid = 1'b1;
            stim[t+1+nwait+dly].rdata  = rdata;
            exp_c[t+2+nwait+dly].resp_valid  = 1'b1;
            exp_c[t+2+nwait+dly].rdata_known = 1'b1;
            exp_c[t+2+nwait+dly].rdata       = wen ? 64'd0 : model_load(rdata, addr, size, uns);
            t_next = t + 2 + nwait + dly;
        end
    endtask

    // Extra directed vectors: wen, size, uns, addr, wdata, rdata, nwait, dly
    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          nwait;
        int          dly;
    } vec_t;

    vec_t vecs [10];

    task automatic plan_all();
        int t;
        int tn;
        for (int c = 0; c < NCYC; c++) begin
            stim[c]  = '{1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 1'b1, 1'b0, GARBAGE, 1'b0};
            exp_c[c] = '{1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b0, 1'b0, 64'd0, 1'b0};
        end
        for (int c = 0; c <= 2; c++) stim[c].rst = 1'b1;
        for (int c = 1; c <= 3; c++) exp_c[c].rdata_known = 1'b1;

        plan_req(5, 1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'd0, 64'hF000_0001_1234_5678, 0, 1, 1'b0, tn);
        plan_req(10, 1'b1, 2'd0, 1'b0, 64'h8000_0003, 64'hAB, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1'b0, tn);
        plan_req(15, 1'b0, 2'd3, 1'b0, 64'h8000_1000, 64'd0, 64'h0123_4567_89AB_CDEF, 4, 1, 1'b0, tn);
        stim[17].rvalid   = 1'b1;
        stim[18].rq_valid = 1'b1;
        stim[18].rq_addr  = 64'h40;
        plan_req(24, 1'b0, 2'd1, 1'b0, 64'h8000_0001, 64'd0, 64'd0, 0, 1, 1'b0, tn);
        stim[26].rvalid = 1'b1;
        plan_req(28, 1'b0, 2'd2, 1'b0, 64'h8000_0010, 64'd0, 64'h1111_2222_3333_4444, 0, 2, 1'b1, tn);
        plan_req(34, 1'b0, 2'd0, 1'b1, 64'h8000_0007, 64'd0, 64'h80FF_FFFF_FFFF_FFFF, 0, 1, 1'b0, tn);
        plan_req(tn, 1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'h1234_5678, GARBAGE, 0, 1, 1'b0, tn);

        vecs[0] = '{1'b0, 2'd1, 1'b0, 64'h8000_0002, 64'd0, 64'h0000_0000_8001_0000, 0, 1};
        vecs[1] = '{1'b0, 2'd1, 1'b1, 64'h8000_0006, 64'd0, 64'hBEEF_0000_0000_0000, 1, 1};
        vecs[2] = '{1'b0, 2'd0, 1'b0, 64'h8000_0005, 64'd0, 64'h0000_7F00_0000_0000, 0, 2};
        vecs[3] = '{1'b1, 2'd1, 1'b0, 64'h8000_0002, 64'hDEAD_BEEF_CAFE_1234, GARBAGE, 0, 1};
        vecs[4] = '{1'b1, 2'd3, 1'b0, 64'h8000_0008, 64'h0102_0304_0506_0708, GARBAGE, 2, 3};
        vecs[5] = '{1'b0, 2'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'h9000_0000_0000_0000, 0, 1};
        vecs[6] = '{1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'd0, 64'd0, 0, 1};
        vecs[7] = '{1'b0, 2'd3, 1'b0, 64'h8000_0004, 64'd0, 64'd0, 0, 1};
        vecs[8] = '{1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'd0, 64'h8877_6655_4433_2211, 0, 3};
        vecs[9] = '{1'b0, 2'd0, 1'b0, 64'h8000_0001, 64'd0, 64'h0000_0000_0000_8000, 0, 1};
        t = 42;
        for (int i = 0; i < 10; i++) begin
            plan_req(t, vecs[i].wen, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                     vecs[i].rdata, vecs[i].nwait, vecs[i].dly, 1'b0, tn);
            t = tn + 1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic apply(input int c);
        rst          = stim[c].rst;
        req_valid    = stim[c].rq_valid;
        req_wen      = stim[c].rq_wen;
        req_unsigned = stim[c].rq_uns;
        req_size     = MemSize'(stim[c].rq_size);
        req_addr     = stim[c].rq_addr;
        req_wdata    = stim[c].rq_wdata;
        bus.ready    = stim[c].ready;
        bus.rvalid   = stim[c].rvalid;
        bus.rdata    = stim[c].rdata;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < NCYC) begin
            check("req_ready",  64'(req_ready),  64'(exp_c[cyc].ready));
            check("bus_valid",  64'(bus.valid),  64'(exp_c[cyc].bus_valid));
            check("misalign",   64'(misalign),   64'(exp_c[cyc].misalign));
            check("resp_valid", 64'(resp_valid), 64'(exp_c[cyc].resp_valid));
            if (exp_c[cyc].bus_valid) begin
                check("bus_addr",  bus.addr,       exp_c[cyc].addr);
                check("bus_wen",   64'(bus.wen),   64'(exp_c[cyc].wen));
                check("bus_wdata", bus.wdata,      exp_c[cyc].wdata);
                check("bus_wmask", 64'(bus.wmask), 64'(exp_c[cyc].wmask));
            end
            if (exp_c[cyc].rdata_known) check("resp_rdata", resp_rdata, exp_c[cyc].rdata);

            // Hand-computed anchors for the model.
            case (cyc)
                1:  check("pin_reset_rdata", resp_rdata, 64'd0);
                8: begin
                    check("pin_lw_resp", 64'(resp_valid), 64'd1);
                    check("pin_lw_rdata", resp_rdata, 64'hFFFF_FFFF_F000_0001);
                end
                11: begin
                    check("pin_sb_wen",   64'(bus.wen), 64'd1);
                    check("pin_sb_wdata", bus.wdata, 64'h0000_0000_AB00_0000);
                    check("pin_sb_wmask", 64'(bus.wmask), 64'h08);
                end
                13: begin
                    check("pin_sb_resp",  64'(resp_valid), 64'd1);
                    check("pin_sb_rdata", resp_rdata, 64'd0);
                end
                20: check("pin_ld_valid_last", 64'(bus.valid), 64'd1);
                21: check("pin_ld_no_early_resp", 64'(resp_valid), 64'd0);
                22: check("pin_ld_resp", 64'(resp_valid), 64'd1);
                25: check("pin_lh_misalign", 64'(misalign), 64'd1);
                26: check("pin_lh_misalign_end", 64'(misalign), 64'd0);
                31: check("pin_rst_bus_idle", 64'(bus.valid), 64'd0);
                32: check("pin_rst_no_resp", 64'(resp_valid), 64'd0);
                37: check("pin_lbu_rdata", resp_rdata, 64'h80);
                38: check("pin_b2b_valid", 64'(bus.valid), 64'd1);
                default: ;
            endcase
        end
    end

    initial begin
        plan_all();
        apply(0);
        for (int c = 1; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            apply(c);
        end
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
